// File: rtl/slc3_mem_responder.sv
// SLC-3 memory responder: services Mem_OE/Mem_WE accesses from an on-chip word
// array after programmable wait states, with one memory-mapped I/O word
// (reads return Switches, writes land in Hex_out) and a preload port for IDLE.
module slc3_mem_responder #(
    parameter int          DEPTH_LOG2 = 8,
    parameter int          RD_WAIT    = 1,
    parameter int          WR_WAIT    = 1,
    parameter logic [15:0] IO_ADDR    = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_from_CPU,
    output logic [15:0] Data_to_CPU,
    output logic        Ready,
    output logic        Err,
    input  logic [15:0] Switches,
    output logic [15:0] Hex_out,
    input  logic        Init_WE,
    input  logic [15:0] Init_Addr,
    input  logic [15:0] Init_Data
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_BUSY = 2'd1,
        WR_BUSY = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic [15:0]   hex_q, hex_d;

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr;
    logic [15:0]           mem_wdata;
    logic [15:0]           mem [DEPTH];

    // Upper preload address bits alias away; only the low bits index the array.
    logic init_addr_hi_unused;
    assign init_addr_hi_unused = ^Init_Addr[15:DEPTH_LOG2];

    // Next-state, wait counting, completion and array write-port selection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        hex_d     = hex_q;
        mem_we    = 1'b0;
        mem_waddr = Init_Addr[DEPTH_LOG2-1:0];
        mem_wdata = Init_Data;
        case (state_q)
            IDLE: begin
                // Preload wins the edge; a pending request is a level and is
                // picked up on the next IDLE edge.
                if (Init_WE) begin
                    mem_we = 1'b1;
                end else if (Mem_OE && Mem_WE) begin
                    err_d = 1'b1;
                end else if (Mem_OE) begin
                    addr_d  = ADDR;
                    cnt_d   = 4'(RD_WAIT - 1);
                    state_d = RD_BUSY;
                end else if (Mem_WE) begin
                    addr_d  = ADDR;
                    wdata_d = Data_from_CPU;
                    cnt_d   = 4'(WR_WAIT - 1);
                    state_d = WR_BUSY;
                end
            end
            RD_BUSY: begin
                if (!Mem_OE) begin
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d = (addr_q == IO_ADDR) ? Switches
                                                  : mem[addr_q[DEPTH_LOG2-1:0]];
                    ready_d = 1'b1;
                    state_d = RELEASE;
                end
            end
            WR_BUSY: begin
                if (!Mem_WE) begin
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (addr_q == IO_ADDR) begin
                        hex_d = wdata_q;
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = addr_q[DEPTH_LOG2-1:0];
                        mem_wdata = wdata_q;
                    end
                    ready_d = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // Hold off until the CPU drops its request so it is never serviced twice.
                if (!Mem_OE && !Mem_WE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 16'h0000;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            hex_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            hex_q   <= hex_d;
        end
    end

    // Latched access address and write data need no reset.
    always_ff @(posedge Clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // Single-port array write; reset cancels any commit in flight.
    always_ff @(posedge Clk) begin
        if (mem_we && !Reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign Data_to_CPU = rdata_q;
    assign Ready       = ready_q;
    assign Err         = err_q;
    assign Hex_out     = hex_q;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Directed bench for slc3_mem_responder with RD_WAIT=1, WR_WAIT=3.
module tb_slc3_mem_responder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Mem_OE;
    logic        Mem_WE;
    logic [15:0] ADDR;
    logic [15:0] Data_from_CPU;
    logic [15:0] Data_to_CPU;
    logic        Ready;
    logic        Err;
    logic [15:0] Switches;
    logic [15:0] Hex_out;
    logic        Init_WE;
    logic [15:0] Init_Addr;
    logic [15:0] Init_Data;

    int n_checks = 0;
    int n_errors = 0;

    slc3_mem_responder #(
        .DEPTH_LOG2(8),
        .RD_WAIT   (1),
        .WR_WAIT   (3),
        .IO_ADDR   (16'hFFFF)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Mem_OE       (Mem_OE),
        .Mem_WE       (Mem_WE),
        .ADDR         (ADDR),
        .Data_from_CPU(Data_from_CPU),
        .Data_to_CPU  (Data_to_CPU),
        .Ready        (Ready),
        .Err          (Err),
        .Switches     (Switches),
        .Hex_out      (Hex_out),
        .Init_WE      (Init_WE),
        .Init_Addr    (Init_Addr),
        .Init_Data    (Init_Data)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are observed 1 ns after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        Init_WE = 1'b1; Init_Addr = a; Init_Data = d;
        step();
        Init_WE = 1'b0;
    endtask

    // RD_WAIT=1: Ready and data appear one cycle after the request is sampled.
    task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
        Mem_OE = 1'b1; ADDR = a;
        step();
        chk({tag, "_rdy_early"}, 16'(Ready), 16'h0);
        step();
        chk({tag, "_rdy"}, 16'(Ready), 16'h1);
        chk({tag, "_data"}, Data_to_CPU, exp);
        Mem_OE = 1'b0;
        step();
        chk({tag, "_rdy_drop"}, 16'(Ready), 16'h0);
    endtask

    // WR_WAIT=3: Ready appears three edges after the request is sampled.
    task automatic wr(input string tag, input logic [15:0] a, input logic [15:0] d);
        Mem_WE = 1'b1; ADDR = a; Data_from_CPU = d;
        step();
        step();
        step();
        chk({tag, "_rdy_early"}, 16'(Ready), 16'h0);
        step();
        chk({tag, "_rdy"}, 16'(Ready), 16'h1);
        Mem_WE = 1'b0;
        step();
        chk({tag, "_rdy_drop"}, 16'(Ready), 16'h0);
    endtask

    initial begin
        Reset = 1'b1; Mem_OE = 1'b0; Mem_WE = 1'b0; ADDR = 16'h0;
        Data_from_CPU = 16'h0; Switches = 16'h0; Init_WE = 1'b0;
        Init_Addr = 16'h0; Init_Data = 16'h0;
        step();
        step();
        chk("rst_data", Data_to_CPU, 16'h0000);
        chk("rst_ready", 16'(Ready), 16'h0);
        chk("rst_err", 16'(Err), 16'h0);
        chk("rst_hex", Hex_out, 16'h0000);
        Reset = 1'b0;
        step();

        preload(16'h0010, 16'h1234);
        preload(16'h0020, 16'h1111);
        preload(16'h0030, 16'h7777);
        preload(16'h0040, 16'h4444);
        preload(16'h00FF, 16'hCAFE);

        // Read with OE held one extra cycle: single Ready pulse, then RELEASE.
        Mem_OE = 1'b1; ADDR = 16'h0010;
        step();
        chk("rd1_rdy_early", 16'(Ready), 16'h0);
        step();
        chk("rd1_rdy", 16'(Ready), 16'h1);
        chk("rd1_data", Data_to_CPU, 16'h1234);
        step();
        chk("rd1_no_repeat", 16'(Ready), 16'h0);
        step();
        chk("rd1_held", 16'(Ready), 16'h0);
        Mem_OE = 1'b0;
        step();

        // Write with wait states; a preload strobe while busy must be ignored.
        Mem_WE = 1'b1; ADDR = 16'h0020; Data_from_CPU = 16'hBEEF;
        step();
        Init_WE = 1'b1; Init_Addr = 16'h0040; Init_Data = 16'h9999;
        step();
        Init_WE = 1'b0;
        chk("wr1_rdy_w1", 16'(Ready), 16'h0);
        step();
        chk("wr1_rdy_w2", 16'(Ready), 16'h0);
        step();
        chk("wr1_rdy", 16'(Ready), 16'h1);
        step();
        chk("wr1_rdy_held", 16'(Ready), 16'h0);
        Mem_WE = 1'b0;
        step();
        chk("wr1_hex", Hex_out, 16'h0000);
        rd("rd_beef", 16'h0020, 16'hBEEF);
        rd("rd_init_busy", 16'h0040, 16'h4444);

        // I/O word: write goes to Hex_out only; read returns Switches.
        wr("wr_io", 16'hFFFF, 16'h00A5);
        chk("io_hex", Hex_out, 16'h00A5);
        rd("rd_alias", 16'h00FF, 16'hCAFE);
        Switches = 16'h5A5A;
        rd("rd_io", 16'hFFFF, 16'h5A5A);
        rd("rd_high_alias", 16'h0110, 16'h1234);

        // Aborted write: WE dropped after one cycle.
        Mem_WE = 1'b1; ADDR = 16'h0030; Data_from_CPU = 16'hDEAD;
        step();
        Mem_WE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_rdy", 16'(Ready), 16'h0);
        end
        rd("abort_keep", 16'h0030, 16'h7777);

        // OE and WE together: one Err pulse, no Ready, data unchanged.
        Mem_OE = 1'b1; Mem_WE = 1'b1; ADDR = 16'h0010;
        step();
        chk("both_err", 16'(Err), 16'h1);
        chk("both_rdy", 16'(Ready), 16'h0);
        Mem_OE = 1'b0; Mem_WE = 1'b0;
        step();
        chk("both_err_drop", 16'(Err), 16'h0);
        chk("both_rdy2", 16'(Ready), 16'h0);
        chk("both_data", Data_to_CPU, 16'h7777);

        // Reset while a read is in flight.
        Mem_OE = 1'b1; ADDR = 16'h0010;
        step();
        Reset = 1'b1;
        step();
        chk("mrst_data", Data_to_CPU, 16'h0000);
        chk("mrst_rdy", 16'(Ready), 16'h0);
        chk("mrst_hex", Hex_out, 16'h0000);
        Reset = 1'b0; Mem_OE = 1'b0;
        step();
        rd("mrst_keep", 16'h0010, 16'h1234);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
